// File: rtl/axil_arbiter_priority_rd.sv
// Fixed-priority AXI-Lite read arbiter: NUM_MASTERS upstream masters share one
// downstream slave read port. Granted requests that fall outside the slave
// window are answered locally with DECERR so the slave never sees them.
module axil_arbiter_priority_rd #(
    parameter int NUM_MASTERS    = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] SLV_ADDR_BASE = 32'h4000_0000,
    parameter logic [AXI_ADDR_WIDTH-1:0] SLV_ADDR_MASK = 32'hF000_0000
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [NUM_MASTERS-1:0]                s_axil_arvalid,
    output logic [NUM_MASTERS-1:0]                s_axil_arready,
    output logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0] s_axil_rdata,
    output logic [NUM_MASTERS*2-1:0]              s_axil_rresp,
    output logic [NUM_MASTERS-1:0]                s_axil_rvalid,
    input  logic [NUM_MASTERS-1:0]                s_axil_rready,
    output logic [AXI_ADDR_WIDTH-1:0]             m_axil_araddr,
    output logic                                  m_axil_arvalid,
    input  logic                                  m_axil_arready,
    input  logic [AXI_DATA_WIDTH-1:0]             m_axil_rdata,
    input  logic [1:0]                            m_axil_rresp,
    input  logic                                  m_axil_rvalid,
    output logic                                  m_axil_rready,
    output logic [NUM_MASTERS-1:0]                grant
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FWD_AR = 3'd1;
    localparam logic [2:0] ST_FWD_R  = 3'd2;
    localparam logic [2:0] ST_ERR_AR = 3'd3;
    localparam logic [2:0] ST_ERR_R  = 3'd4;

    // Per-master views of the flat buses.
    logic [NUM_MASTERS-1:0][AXI_ADDR_WIDTH-1:0] s_addr;
    logic [NUM_MASTERS-1:0][AXI_DATA_WIDTH-1:0] rdata_v;
    logic [NUM_MASTERS-1:0][1:0]                rresp_v;

    assign s_addr       = s_axil_araddr;
    assign s_axil_rdata = rdata_v;
    assign s_axil_rresp = rresp_v;

    logic [2:0]             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          gidx_q, gidx_d;
    logic                   err_ar_q, err_ar_d;   // local AR accept pulse
    logic                   err_r_q, err_r_d;     // local DECERR beat valid

    logic [IW-1:0]             win_idx;
    logic                      win_vld;
    logic [AXI_ADDR_WIDTH-1:0] win_addr;
    logic                      in_win;

    // Lowest requesting index wins; scan downward so the last hit is the lowest.
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (s_axil_arvalid[i]) begin
                win_idx = IW'(i);
                win_vld = 1'b1;
            end
        end
        win_addr = s_addr[win_idx];
        in_win   = (win_addr & SLV_ADDR_MASK) == (SLV_ADDR_BASE & SLV_ADDR_MASK);
    end

    logic fwd_ar, fwd_r;
    assign fwd_ar = (state_q == ST_FWD_AR);
    assign fwd_r  = (state_q == ST_FWD_R);

    // Downstream port is only driven while a forwarded transaction owns it.
    assign m_axil_araddr  = fwd_ar ? s_addr[gidx_q] : '0;
    assign m_axil_arvalid = fwd_ar & s_axil_arvalid[gidx_q];
    assign m_axil_rready  = fwd_r & s_axil_rready[gidx_q];
    assign grant          = grant_q;

    // Transaction sequencing; the grant is held until the R handshake.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        err_ar_d = 1'b0;
        err_r_d  = err_r_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    grant_d = NUM_MASTERS'(1) << win_idx;
                    gidx_d  = win_idx;
                    if (in_win) begin
                        state_d = ST_FWD_AR;
                    end else begin
                        state_d  = ST_ERR_AR;
                        err_ar_d = 1'b1;
                    end
                end
            end
            ST_FWD_AR: begin
                if (m_axil_arvalid && m_axil_arready) state_d = ST_FWD_R;
            end
            ST_FWD_R: begin
                if (m_axil_rvalid && m_axil_rready) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            ST_ERR_AR: begin
                state_d = ST_ERR_R;
                err_r_d = 1'b1;
            end
            ST_ERR_R: begin
                if (s_axil_rready[gidx_q]) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    err_r_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                err_r_d = 1'b0;
            end
        endcase
    end

    // State registers; reset abandons any transaction in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            err_ar_q <= 1'b0;
            err_r_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            err_ar_q <= err_ar_d;
            err_r_q  <= err_r_d;
        end
    end

    // Upstream responses: only the granted master ever sees non-zero values.
    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_mst
        logic sel_fwd_ar, sel_fwd_r, sel_err_r;
        assign sel_fwd_ar        = grant_q[i] & fwd_ar;
        assign sel_fwd_r         = grant_q[i] & fwd_r;
        assign sel_err_r         = grant_q[i] & err_r_q;
        assign s_axil_arready[i] = (sel_fwd_ar & m_axil_arready) | (grant_q[i] & err_ar_q);
        assign s_axil_rvalid[i]  = (sel_fwd_r & m_axil_rvalid) | sel_err_r;
        assign rdata_v[i]        = sel_fwd_r ? m_axil_rdata : (sel_err_r ? '1 : '0);
        assign rresp_v[i]        = sel_fwd_r ? m_axil_rresp : (sel_err_r ? 2'b11 : 2'b00);
    end

endmodule

// File: tb/tb_axil_arbiter_priority_rd.sv
// Bench for the fixed-priority read arbiter: master and slave behavioural
// models, a transaction-level scoreboard and directed plus random traffic.
module tb_axil_arbiter_priority_rd;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b1;
    logic [N*AW-1:0] s_araddr = '0;
    logic [N-1:0]    s_arvalid = '0;
    logic [N-1:0]    s_arready;
    logic [N*DW-1:0] s_rdata;
    logic [N*2-1:0]  s_rresp;
    logic [N-1:0]    s_rvalid;
    logic [N-1:0]    s_rready = '0;
    logic [AW-1:0]   m_araddr;
    logic            m_arvalid;
    logic            m_arready = 1'b0;
    logic [DW-1:0]   m_rdata = '0;
    logic [1:0]      m_rresp = '0;
    logic            m_rvalid = 1'b0;
    logic            m_rready;
    logic [N-1:0]    grant;

    axil_arbiter_priority_rd #(.NUM_MASTERS(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axil_araddr(s_araddr), .s_axil_arvalid(s_arvalid), .s_axil_arready(s_arready),
        .s_axil_rdata(s_rdata), .s_axil_rresp(s_rresp), .s_axil_rvalid(s_rvalid),
        .s_axil_rready(s_rready),
        .m_axil_araddr(m_araddr), .m_axil_arvalid(m_arvalid), .m_axil_arready(m_arready),
        .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp), .m_axil_rvalid(m_rvalid),
        .m_axil_rready(m_rready), .grant(grant)
    );

    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- models ----------------
    logic [AW-1:0] req_q[N][$];
    int            mst_st[N];          // 0 idle, 1 AR pending, 2 waiting R
    logic [AW-1:0] mst_addr[N];
    int            rr_wait[N];
    int            ar_hi[N];
    int            issued[N];
    int            done[N];
    logic [33:0]   last_beat[N];
    int            order[$];

    int          slv_st = 0;           // 0 AR phase, 1 R latency, 2 R valid
    int          slv_wait = 0;
    logic [DW-1:0] slv_rdata = '0;
    logic [1:0]  slv_rresp = '0;
    bit          slv_fix = 0;
    int          ar_dly = 0, r_dly = 0, rr_dly = 0;   // <0 means random 0..4
    int          m_ar_cnt = 0;

    logic [N-1:0] prev_grant = '0, prev_arvalid = '0, prev_stall = '0;
    logic         prev_rdone = 1'b0;
    logic [33:0]  prev_beat[N];
    logic [N-1:0] seen_grant = '0;

    function automatic int dly(int k);
        return (k < 0) ? int'($urandom_range(4, 0)) : k;
    endfunction

    function automatic bit inwin(logic [AW-1:0] a);
        return (a & 32'hF000_0000) == 32'h4000_0000;
    endfunction

    function automatic logic [N-1:0] lowest(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return N'(1) << i;
        return '0;
    endfunction

    function automatic int idx_of(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [33:0] beat_of(int m);
        return {s_rdata[m*DW +: DW], s_rresp[m*2 +: 2]};
    endfunction

    // One clock: check at negedge, advance the models just after posedge.
    task automatic step();
        logic [N-1:0] ar_hs, r_hs, rv_seen, exp_g;
        logic [35:0]  quiet;
        logic         m_ar_hs, m_r_hs, m_av_seen;
        int           g;
        @(negedge aclk);
        ar_hs = s_arvalid & s_arready;
        r_hs  = s_rvalid & s_rready;
        rv_seen = s_rvalid;
        m_ar_hs = m_arvalid & m_arready;
        m_r_hs  = m_rvalid & m_rready;
        m_av_seen = m_arvalid;

        if (prev_grant == '0)  exp_g = lowest(prev_arvalid);
        else if (prev_rdone)   exp_g = '0;
        else                   exp_g = prev_grant;
        chk("grant", grant, exp_g);
        seen_grant |= grant;

        quiet = '0;
        for (int m = 0; m < N; m++)
            if (!grant[m]) quiet |= {s_arready[m], s_rvalid[m], beat_of(m)};
        chk("quiet", quiet, 0);

        g = idx_of(grant);
        if (grant == '0) chk("m_idle", {m_arvalid, m_rready, m_araddr}, 0);
        else if (!inwin(mst_addr[g])) chk("err_no_m", {m_arvalid, m_rready, m_araddr}, 0);

        for (int m = 0; m < N; m++) begin
            if (prev_stall[m]) chk("stall_hold", {s_rvalid[m], beat_of(m)}, {1'b1, prev_beat[m]});
            if (s_arready[m]) ar_hi[m]++;
            if (r_hs[m]) begin
                chk("r_state", mst_st[m], 2);
                chk("rbeat", beat_of(m), inwin(mst_addr[m]) ? {slv_rdata, slv_rresp} : {32'hFFFF_FFFF, 2'b11});
                chk("ar_pulse", ar_hi[m], 1);
                last_beat[m] = beat_of(m);
                order.push_back(m);
            end
            prev_beat[m] = beat_of(m);
        end
        if (m_ar_hs) begin
            chk("m_araddr", m_araddr, mst_addr[g]);
            m_ar_cnt++;
        end
        prev_grant   = grant;
        prev_arvalid = s_arvalid;
        prev_rdone   = |(r_hs & grant);
        prev_stall   = s_rvalid & ~s_rready;

        @(posedge aclk); #1;
        for (int m = 0; m < N; m++) begin
            case (mst_st[m])
                0: if (req_q[m].size() > 0) begin
                    mst_addr[m] = req_q[m].pop_front();
                    s_araddr[m*AW +: AW] = mst_addr[m];
                    s_arvalid[m] = 1'b1;
                    mst_st[m] = 1;
                    ar_hi[m] = 0;
                    issued[m]++;
                end
                1: if (ar_hs[m]) begin
                    s_arvalid[m] = 1'b0;
                    mst_st[m] = 2;
                    rr_wait[m] = dly(rr_dly);
                end
                default: if (r_hs[m]) begin
                    s_rready[m] = 1'b0;
                    mst_st[m] = 0;
                    done[m]++;
                end else if (rv_seen[m]) begin
                    if (rr_wait[m] == 0) s_rready[m] = 1'b1;
                    else rr_wait[m]--;
                end
            endcase
        end
        case (slv_st)
            0: if (m_ar_hs) begin
                m_arready = 1'b0;
                slv_st = 1;
                slv_wait = dly(r_dly);
            end else if (m_av_seen) begin
                if (slv_wait == 0) m_arready = 1'b1;
                else slv_wait--;
            end
            1: if (slv_wait == 0) begin
                slv_rdata = slv_fix ? 32'hCAFE_0001 : $urandom;
                slv_rresp = slv_fix ? 2'b00 : 2'($urandom_range(3, 0));
                m_rdata = slv_rdata;
                m_rresp = slv_rresp;
                m_rvalid = 1'b1;
                slv_st = 2;
            end else slv_wait--;
            default: if (m_r_hs) begin
                m_rvalid = 1'b0;
                m_rdata = '0;
                m_rresp = '0;
                slv_st = 0;
                slv_wait = dly(ar_dly);
            end
        endcase
    endtask

    task automatic apply_reset();
        @(posedge aclk); #2;
        aresetn = 1'b0;
        #1;
        chk("rst_s", |{s_arready, s_rvalid, s_rdata, s_rresp}, 0);
        chk("rst_m", {m_arvalid, m_rready, m_araddr}, 0);
        chk("rst_grant", grant, 0);
        s_araddr = '0; s_arvalid = '0; s_rready = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
        for (int m = 0; m < N; m++) begin
            req_q[m].delete();
            mst_st[m] = 0;
            issued[m] = done[m];
        end
        slv_st = 0; slv_wait = dly(ar_dly);
        prev_grant = '0; prev_arvalid = '0; prev_stall = '0; prev_rdone = 1'b0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
    endtask

    task automatic wait_done(input int m, input int tgt, input string tag);
        int k = 0;
        while (done[m] < tgt && k < 300) begin
            step();
            k++;
        end
        chk(tag, done[m], tgt);
    endtask

    task automatic wait_fwd_r(input logic [N-1:0] g, input string tag);
        int k = 0;
        while (!(slv_st == 1 && grant == g) && k < 100) begin
            step();
            k++;
        end
        chk(tag, grant, g);
    endtask

    initial begin
        int mc, t, m;
        bit busy;
        logic [AW-1:0] a;
        for (int i = 0; i < N; i++) begin
            mst_st[i] = 0; issued[i] = 0; done[i] = 0; ar_hi[i] = 0;
            rr_wait[i] = 0; mst_addr[i] = '0; last_beat[i] = '0; prev_beat[i] = '0;
        end
        apply_reset();
        repeat (2) step();

        // single in-window master
        slv_fix = 1; seen_grant = '0;
        req_q[2].push_back(32'h4000_0010);
        wait_done(2, done[2] + 1, "single_done");
        chk("single_grant", seen_grant, 4'b0100);
        chk("single_beat", last_beat[2], {32'hCAFE_0001, 2'b00});
        slv_fix = 0;
        repeat (2) step();

        // simultaneous requests from masters 1 and 3
        order.delete();
        req_q[1].push_back(32'h4000_0100);
        req_q[3].push_back(32'h4000_0300);
        wait_done(3, done[3] + 1, "col_done");
        chk("col_n", order.size(), 2);
        if (order.size() >= 2) begin
            chk("col_first", order[0], 1);
            chk("col_second", order[1], 3);
        end
        repeat (2) step();

        // out of window, master holds rready off for a while
        rr_dly = 3; mc = m_ar_cnt;
        req_q[0].push_back(32'h8000_0000);
        wait_done(0, done[0] + 1, "oow_done");
        chk("oow_no_m_ar", m_ar_cnt - mc, 0);
        chk("oow_beat", last_beat[0], {32'hFFFF_FFFF, 2'b11});
        repeat (2) step();

        // backpressure on both AR and R
        ar_dly = 5; rr_dly = 3; slv_wait = 5;
        req_q[1].push_back(32'h4000_1234);
        wait_done(1, done[1] + 1, "bp_done");
        ar_dly = 0; rr_dly = 0;
        repeat (2) step();

        // no preemption: master 0 arrives while master 2 is in the R phase
        r_dly = 6;
        req_q[2].push_back(32'h4ABC_0000);
        wait_fwd_r(4'b0100, "np_fwd_r");
        order.delete();
        req_q[0].push_back(32'h4000_0004);
        wait_done(0, done[0] + 1, "np_done");
        chk("np_n", order.size(), 2);
        if (order.size() >= 2) begin
            chk("np_first", order[0], 2);
            chk("np_second", order[1], 0);
        end
        repeat (2) step();

        // reset while in the R phase, then a fresh request
        r_dly = 10;
        req_q[1].push_back(32'h4000_0040);
        wait_fwd_r(4'b0010, "rst_fwd_r");
        apply_reset();
        r_dly = 1;
        req_q[3].push_back(32'h4000_0300);
        wait_done(3, done[3] + 1, "post_rst_done");
        repeat (2) step();

        // random traffic
        ar_dly = -1; r_dly = -1; rr_dly = -1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3, 0) == 0) begin
                m = $urandom_range(N - 1, 0);
                a = $urandom;
                if ($urandom_range(1, 0) == 1) a[31:28] = 4'h4;
                else if (a[31:28] == 4'h4) a[31:28] = 4'hC;
                if (req_q[m].size() < 2) req_q[m].push_back(a);
            end
            step();
        end
        t = 0;
        busy = 1;
        while (busy && t < 1000) begin
            step();
            t++;
            busy = 0;
            for (int i = 0; i < N; i++) if (req_q[i].size() > 0 || mst_st[i] != 0) busy = 1;
        end
        for (int i = 0; i < N; i++) chk("drain", done[i], issued[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
